// File: rtl/img_mem_writer.sv
// Streams bytes into OC+1 channel memories, pixel-major/channel-minor, one write per accepted byte.
// Latency 1 cycle from accepted byte to write strobe; s_ready is high only while filling, and stalls simply pause the fill.
// Optional IMG_WRITER_CHECKSUM_EN adds a 16-bit modular byte checksum output valid from done.
module img_mem_writer #(
    parameter int LOAD_ADDR_LEN = 7,
    parameter int OC            = 15,
    parameter int CHANNEL_SIZE  = 195
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     s_valid,
    input  logic signed [7:0]        s_data,
    output logic                     s_ready,
    output logic [OC:0]              wr_en,
    output logic [LOAD_ADDR_LEN:0]   wr_addr,
    output logic signed [7:0]        wr_data,
    output logic                     busy,
`ifdef IMG_WRITER_CHECKSUM_EN
    output logic [15:0]              checksum,
`endif
    output logic                     done
);

    localparam int AW   = LOAD_ADDR_LEN + 1;
    localparam int CH_W = (OC > 0) ? $clog2(OC + 1) : 1;

    localparam logic [CH_W-1:0] CH_LAST   = CH_W'(OC);
    localparam logic [CH_W-1:0] CH_ONE    = CH_W'(1);
    localparam logic [AW-1:0]   ADDR_LAST = AW'(CHANNEL_SIZE - 1);
    localparam logic [AW-1:0]   ADDR_ONE  = AW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [CH_W-1:0]        ch_cnt_q, ch_cnt_d;
    logic [AW-1:0]          addr_cnt_q, addr_cnt_d;
    logic                   s_ready_q, s_ready_d;
    logic [OC:0]            wr_en_q, wr_en_d;
    logic [AW-1:0]          wr_addr_q, wr_addr_d;
    logic signed [7:0]      wr_data_q, wr_data_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   beat;

    // s_ready_q is high exactly in FILL, so it doubles as the FILL qualifier.
    assign beat = s_valid & s_ready_q;

    always_comb begin
        state_d    = state_q;
        ch_cnt_d   = ch_cnt_q;
        addr_cnt_d = addr_cnt_q;
        wr_en_d    = '0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = FILL;
                    ch_cnt_d   = '0;
                    addr_cnt_d = '0;
                end
            end
            FILL: begin
                if (beat) begin
                    if (ch_cnt_q == CH_LAST) begin
                        ch_cnt_d = '0;
                        if (addr_cnt_q == ADDR_LAST) begin
                            addr_cnt_d = '0;
                            state_d    = FLUSH;
                        end else begin
                            addr_cnt_d = addr_cnt_q + ADDR_ONE;
                        end
                    end else begin
                        ch_cnt_d = ch_cnt_q + CH_ONE;
                    end
                end
            end
            FLUSH:   state_d = DONE;
            default: state_d = IDLE;
        endcase

        if (beat) begin
            wr_en_d[ch_cnt_q] = 1'b1;
            wr_addr_d         = addr_cnt_q;
            wr_data_d         = s_data;
        end

        // Status outputs are registered copies of the next state's decode.
        s_ready_d = (state_d == FILL);
        busy_d    = (state_d == FILL) || (state_d == FLUSH);
        done_d    = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            ch_cnt_q   <= '0;
            addr_cnt_q <= '0;
            s_ready_q  <= 1'b0;
            wr_en_q    <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ch_cnt_q   <= ch_cnt_d;
            addr_cnt_q <= addr_cnt_d;
            s_ready_q  <= s_ready_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign s_ready = s_ready_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = busy_q;
    assign done    = done_q;

`ifdef IMG_WRITER_CHECKSUM_EN
    logic [15:0] checksum_q, checksum_d;

    // Bytes are summed as unsigned values; the sum wraps modulo 2^16.
    always_comb begin
        checksum_d = checksum_q;
        if (state_q == IDLE && start) begin
            checksum_d = '0;
        end else if (beat) begin
            checksum_d = checksum_q + {8'h00, s_data};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`endif

endmodule
